// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             funct3,
    input  logic [WORD_LENGTH-1:0] operand_a,
    input  logic [WORD_LENGTH-1:0] operand_b,
    input  logic [4:0]             rd_in,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] result,
    output logic [4:0]             rd_out,
    output logic                   reg_write
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [2:0]      op;
    logic            neg;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [W-1:0]    opnd;
    logic [CW-1:0]   cnt;

    logic            is_div;
    logic            div_signed;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    abs_a;
    logic [W-1:0]    abs_b;
    logic            res_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [W-1:0]    special_res;

    assign is_div     = funct3[2];
    assign div_signed = ~funct3[0];
    assign a_signed   = is_div ? div_signed
                      : (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
    assign b_signed   = is_div ? div_signed : (funct3[1:0] == 2'b01);
    assign a_neg      = a_signed & operand_a[W-1];
    assign b_neg      = b_signed & operand_b[W-1];
    assign abs_a      = a_neg ? -operand_a : operand_a;
    assign abs_b      = b_neg ? -operand_b : operand_b;

    // Remainder follows the dividend sign; quotient and product use the xor.
    assign res_neg = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = is_div && (operand_b == '0);
    assign div_ovf  = is_div && div_signed
                    && (operand_a == {1'b1, {(W-1){1'b0}}})
                    && (operand_b == '1);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? operand_a : '1;
        else
            special_res = funct3[1] ? '0 : operand_a;
    end

    logic            fast_hit;
    logic [W-1:0]    fast_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0]  ext_a;
    logic [2*W-1:0]  ext_b;
    logic [2*W-1:0]  fast_prod;
    assign ext_a     = {{W{a_signed & operand_a[W-1]}}, operand_a};
    assign ext_b     = {{W{b_signed & operand_b[W-1]}}, operand_b};
    assign fast_prod = ext_a * ext_b;
    assign fast_hit  = ~funct3[2];
    assign fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[W-1:0]
                                              : fast_prod[2*W-1:W];
`else
    assign fast_hit  = 1'b0;
    assign fast_res  = '0;
`endif

    // One iteration: hi/lo hold the running product or remainder/quotient.
    logic [W:0]      mul_sum;
    logic [W:0]      div_sh;
    logic            div_ge;
    logic [W-1:0]    div_dif;
    logic [W-1:0]    nxt_hi;
    logic [W-1:0]    nxt_lo;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    calc_res;

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_sh  = {hi, lo[W-1]};
    assign div_ge  = div_sh >= {1'b0, opnd};
    assign div_dif = div_sh[W-1:0] - opnd;
    assign nxt_hi  = op[2] ? (div_ge ? div_dif : div_sh[W-1:0])
                           : mul_sum[W:1];
    assign nxt_lo  = op[2] ? {lo[W-2:0], div_ge}
                           : {mul_sum[0], lo[W-1:1]};

    always_comb begin
        prod     = '0;
        calc_res = '0;
        if (op[2]) begin
            calc_res = op[1] ? nxt_hi : nxt_lo;
            if (neg)
                calc_res = -calc_res;
        end else begin
            prod = {nxt_hi, nxt_lo};
            if (neg)
                prod = -prod;
            calc_res = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            neg       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            reg_write <= 1'b0;
        end else begin
            done      <= 1'b0;
            reg_write <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        neg    <= res_neg;
                        rd_out <= rd_in;
                        cnt    <= '0;
                        hi     <= '0;
                        lo     <= abs_a;
                        opnd   <= abs_b;
                        busy   <= 1'b1;
                        if (div_zero || div_ovf) begin
                            result    <= special_res;
                            state     <= DONE;
                            done      <= 1'b1;
                            reg_write <= (rd_in != 5'd0);
                        end else if (fast_hit) begin
                            result    <= fast_res;
                            state     <= DONE;
                            done      <= 1'b1;
                            reg_write <= (rd_in != 5'd0);
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) begin
                        result    <= calc_res;
                        state     <= DONE;
                        done      <= 1'b1;
                        reg_write <= (rd_out != 5'd0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, writeback, held start, reset abort.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.WORD_LENGTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .funct3(funct3),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .rd_in(rd_in),
        .busy(busy),
        .done(done),
        .result(result),
        .rd_out(rd_out),
        .reg_write(reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        check({tag, " reg_write"}, {31'd0, reg_write}, {31'd0, rd != 5'd0});
        check({tag, " busy in done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, " done falls"}, {31'd0, done}, 32'd0);
        check({tag, " busy falls"}, {31'd0, busy}, 32'd0);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        int done_cnt;
        int first;
        int second;
        int rw_cnt;

        rst       = 1'b1;
        start     = 1'b0;
        funct3    = 3'b000;
        operand_a = '0;
        operand_b = '0;
        rd_in     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        check("reset reg_write", {31'd0, reg_write}, 32'd0);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, MUL_LAT);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, MUL_LAT);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, MUL_LAT);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, DIV_LAT);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, DIV_LAT);
        run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT);
        run_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT);
        run_op("divu0",  3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
        run_op("rem0",   3'b110, 32'h00001234, 32'd0,        5'd14, 32'h00001234, 1);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);

        // start held high across two back-to-back ops with rd=0
        @(negedge clk);
        start     = 1'b1;
        funct3    = 3'b101;
        operand_a = 32'd100;
        operand_b = 32'd7;
        rd_in     = 5'd0;
        done_cnt  = 0;
        first     = 0;
        second    = 0;
        rw_cnt    = 0;
        for (int i = 1; i <= 68; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first == 0) first = i;
                else second = i;
            end
            if (reg_write) rw_cnt++;
            if (i == 34) check("held busy gap", {31'd0, busy}, 32'd0);
            if (i == 35) check("held re-accept", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        check("held done count", done_cnt, 32'd2);
        check("held first done", first, 32'd33);
        check("held second done", second, 32'd67);
        check("held reg_write", rw_cnt, 32'd0);
        check("held result", result, 32'd14);
        check("held idle", {31'd0, busy}, 32'd0);

        // reset pulsed mid-divide
        @(negedge clk);
        start     = 1'b1;
        funct3    = 3'b100;
        operand_a = 32'hFFFFFFF9;
        operand_b = 32'd2;
        rd_in     = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-abort busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", {27'd0, rd_out}, 32'd0);
        check("abort reg_write", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort no done", done_cnt, 32'd0);

        run_op("mul after rst", 3'b000, 32'd3, 32'd4, 5'd1, 32'd12, MUL_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes the two source operands (data_1, data_2) read for an M-extension instruction.
- Returns its result to the register file write port: result -> write_data, rd_out -> write_add, reg_write -> write_enable.
- The core stalls on busy while an operation is in flight.

Parameters:
- WORD_LENGTH, 32, operand/result width. Iteration count equals WORD_LENGTH. Only 32 is required to be verified.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when idle.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  WORD_LENGTH  rs1 value.
- operand_b  input  WORD_LENGTH  rs2 value.
- rd_in  input  5  destination register address.
- busy  output  1  high while an op is in flight (CALC and DONE states).
- done  output  1  one-cycle pulse; result valid.
- result  output  WORD_LENGTH  final result; held until next accepted start.
- rd_out  output  5  latched rd_in.
- reg_write  output  1  equals done AND (rd_out != 0).

Behaviour:
Reset:
- rst high (asynchronous) forces state IDLE and zeroes busy, done, result, rd_out, reg_write and all internal registers.
- Applies at any time, including mid-operation; the aborted op produces no done.

States: IDLE, CALC, DONE.

Start acceptance:
- IDLE and start=1 at edge E0: latch funct3, operands, rd_in; clear iteration counter.
- Next state is CALC, or DONE directly for special cases.
- start while busy is ignored; the op is not queued.
- start in IDLE with no other activity is never dropped.

Multiply:
- Signed operands are sign-extended to 2*WORD_LENGTH per op: MULH both signed, MULHSU a signed / b unsigned.
- Shift-add, one bit per CALC cycle.
- MUL returns the low word; MULH/MULHSU/MULHU return the high word of the 2*WORD_LENGTH product.

Divide:
- Restoring divide on magnitudes, one quotient bit per CALC cycle.
- Signed ops: quotient negated if operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient all ones; remainder = operand_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000; remainder 0.
- Both special cases skip CALC: IDLE -> DONE at E0.

Latency:
- CALC lasts exactly WORD_LENGTH edges. At the WORD_LENGTH-th CALC edge, result is registered and state moves to DONE.
- done is high for the single cycle in DONE. The next edge returns to IDLE.
- Normal op: done visible in the cycle after edge E0+WORD_LENGTH (33 edges of busy for 32-bit).
- Special-case op: done in the cycle after E0.
- busy deasserts in the same edge that leaves DONE, so a new start is accepted one cycle after done.

Writeback:
- rd_out=0: done still pulses; reg_write stays 0.
- No handshake back-pressure; the consumer must accept in the done cycle.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: multiply ops (funct3[2]=0) use a single-cycle combinational 2*WORD_LENGTH product, registered at E0, going IDLE -> DONE. done appears in the cycle after start. Divide behaviour is unchanged.
- Undefined: all multiplies are iterative with the WORD_LENGTH-cycle CALC path. No combinational multiplier is instantiated.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (-3), rd_in=5 -> result 0xFFFFFFEB, rd_out=5, reg_write=1, done exactly 33 edges after start (1 with MULDIV_FAST_MUL_EN).
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF with done one cycle after start. REM a=0x80000000, b=0xFFFFFFFF -> 0 with done one cycle after start. DIV same operands -> 0x80000000.
- start held high for the entire op, then rd_in=0 -> exactly one done per accepted op, second request accepted the cycle after done, reg_write stays 0 for rd=0.
- rst pulsed at CALC iteration 10 of a DIV -> all outputs 0 immediately, no done pulse; a fresh MUL 3*4 afterward returns 12.
